// File: rtl/core_pkg.sv
// Shared core definitions for the hazard/flush controller.
//   hazard_state_t  : hazard FSM states (RUN, MEM_WAIT, HALT)
//   FWD_*           : execute-stage operand forward selects
//   RESULT_SRC_LOAD : ResultSrcE encoding that marks a load
//   fwd_sel()       : forward select for one execute source register
package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // M stage wins over W: it holds the younger result for the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_M;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
        else                                             return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug activity counts.
//   clk, rst : clock, async active-high reset (clears to 0)
//   inc      : count this cycle
//   cnt_o    : current count, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       cnt_q <= '0;
        else if (inc && (cnt_q != '1)) cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller for the 5-stage RV32 core.
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, ResultSrcE, PCSrcE : decode/execute hazard inputs
//   RdM/RegWriteM, RdW/RegWriteW                 : forwarding sources
//   MemReqM/MemReadyM                            : data memory handshake
//   StallF/D/E/M, FlushD/E/W                     : stage register hold / clr
//   ForwardAE/BE                                 : execute operand selects
//   MemTimeoutErr                                : sticky memory-wait timeout
//   StallCnt/FlushCnt                            : saturating debug counters
module hazard_ctrl
    import core_pkg::*;
#(
    parameter logic [1:0] LOAD_SRC    = RESULT_SRC_LOAD,
    parameter int         MEM_TIMEOUT = 256,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeoutErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_stall, lw_stall, halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        halt      = (state_q == HALT);
        mem_stall = MemReqM & ~MemReadyM & ~halt;
        unique case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                // A dropped request counts as completion.
                if (!MemReqM || MemReadyM)  state_d = RUN;
                else if (wait_q == WAIT_LAST) state_d = HALT;
                else                        wait_d  = wait_q + WAIT_W'(1);
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    assign lw_stall = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    assign StallF = lw_stall | mem_stall | halt;
    assign StallD = StallF;
    assign StallE = mem_stall | halt;
    assign StallM = StallE;
    // While E is frozen PCSrcE persists, so the redirect flush is deferred, not lost.
    assign FlushD = PCSrcE & ~mem_stall & ~halt;
    assign FlushE = (lw_stall | PCSrcE) & ~mem_stall & ~halt;
    assign FlushW = mem_stall | halt;

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign MemTimeoutErr = halt;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (StallF),
        .cnt_o (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (FlushD),
        .cnt_o (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic [1:0] ResultSrcE = '0;
    logic       PCSrcE = 0, RegWriteM = 0, RegWriteW = 0, MemReqM = 0, MemReadyM = 0;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeoutErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt, FlushCnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_SRC(2'b01), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM),
        .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .MemReqM(MemReqM),
        .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeoutErr(MemTimeoutErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: the core halts once the memory has refused the same
    // access for TO+1 back-to-back cycles (one noticing it, TO waiting).
    bit m_halt   = 0;
    int m_consec = 0;
    int m_scnt   = 0;
    int m_fcnt   = 0;

    function automatic logic [1:0] efwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk or posedge rst) begin
        bit ms, lw, hl, e_sf, e_se, e_fd, e_fe;
        if (rst) begin
            m_halt = 0; m_consec = 0; m_scnt = 0; m_fcnt = 0;
        end
        if (!clk && $time > 0) begin
            hl   = m_halt;
            ms   = MemReqM && !MemReadyM && !hl;
            lw   = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
            e_sf = lw || ms || hl;
            e_se = ms || hl;
            e_fd = PCSrcE && !ms && !hl;
            e_fe = (lw || PCSrcE) && !ms && !hl;
            chk("StallF", 32'(StallF), 32'(e_sf));
            chk("StallD", 32'(StallD), 32'(e_sf));
            chk("StallE", 32'(StallE), 32'(e_se));
            chk("StallM", 32'(StallM), 32'(e_se));
            chk("FlushD", 32'(FlushD), 32'(e_fd));
            chk("FlushE", 32'(FlushE), 32'(e_fe));
            chk("FlushW", 32'(FlushW), 32'(e_se));
            chk("ForwardAE", 32'(ForwardAE), 32'(efwd(Rs1E)));
            chk("ForwardBE", 32'(ForwardBE), 32'(efwd(Rs2E)));
            chk("MemTimeoutErr", 32'(MemTimeoutErr), 32'(hl));
            chk("StallCnt", 32'(StallCnt), 32'(m_scnt));
            chk("FlushCnt", 32'(FlushCnt), 32'(m_fcnt));
            if (!rst) begin
                if (e_sf && m_scnt < CMAX) m_scnt++;
                if (e_fd && m_fcnt < CMAX) m_fcnt++;
                if (!hl) begin
                    if (ms) begin
                        m_consec++;
                        if (m_consec == TO + 1) m_halt = 1;
                    end else m_consec = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic clr_in();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic set_lw();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and combinational outputs during reset
        step(); step();
        chk("rst_StallCnt", 32'(StallCnt), 0);
        chk("rst_Err", 32'(MemTimeoutErr), 0);
        chk("rst_StallF", 32'(StallF), 0);
        set_lw(); #1;
        chk("rst_lw_StallF", 32'(StallF), 1);
        chk("rst_lw_StallE", 32'(StallE), 0);
        clr_in(); #1;
        rst = 0;

        // Load-use hazard for one cycle
        step(); set_lw();
        at_neg();
        chk("lu_StallF", 32'(StallF), 1);
        chk("lu_StallD", 32'(StallD), 1);
        chk("lu_FlushE", 32'(FlushE), 1);
        chk("lu_StallE", 32'(StallE), 0);
        step(); clr_in();
        at_neg();
        chk("lu_cnt", 32'(StallCnt), 1);
        chk("lu_done", 32'(StallF), 0);

        // Forward priority
        step();
        RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 1; #1;
        chk("fwd_M", 32'(ForwardAE), 2);
        chk("fwd_M_B", 32'(ForwardBE), 2);
        RdM = 0; #1;
        chk("fwd_W", 32'(ForwardAE), 1);
        RdM = 7; RegWriteM = 0; #1;
        chk("fwd_W_nowrM", 32'(ForwardAE), 1);
        Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; #1;
        chk("fwd_x0", 32'(ForwardAE), 0);
        Rs2E = 9; RdW = 9; #1;
        chk("fwd_B_W", 32'(ForwardBE), 1);
        step(); clr_in();

        // Load-use together with redirect
        set_lw(); PCSrcE = 1; #1;
        chk("lwpc_FlushD", 32'(FlushD), 1);
        chk("lwpc_FlushE", 32'(FlushE), 1);
        chk("lwpc_StallF", 32'(StallF), 1);
        step(); clr_in();

        // Memory wait with pending redirect
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("mw_StallF", 32'(StallF), 1);
            chk("mw_StallM", 32'(StallM), 1);
            chk("mw_FlushW", 32'(FlushW), 1);
            chk("mw_FlushD", 32'(FlushD), 0);
            step();
        end
        MemReadyM = 1; #1;
        chk("mw_rdy_FlushD", 32'(FlushD), 1);
        chk("mw_rdy_FlushE", 32'(FlushE), 1);
        chk("mw_rdy_StallF", 32'(StallF), 0);
        step(); clr_in();
        chk("mw_state_run", 32'(dut.state_q), 0);
        chk("mw_StallCnt", 32'(StallCnt), 5);
        chk("mw_FlushCnt", 32'(FlushCnt), 2);

        // Request dropped while waiting
        MemReqM = 1; step(); step();
        MemReqM = 0; step();
        chk("drop_state_run", 32'(dut.state_q), 0);

        // Ready on the last permitted wait cycle
        MemReqM = 1; MemReadyM = 0;
        repeat (4) step();
        MemReadyM = 1; step(); clr_in();
        chk("edge_state_run", 32'(dut.state_q), 0);
        chk("edge_noerr", 32'(MemTimeoutErr), 0);
        step();

        // Timeout into HALT
        MemReqM = 1;
        repeat (5) step();
        chk("to_err", 32'(MemTimeoutErr), 1);
        MemReqM = 0; PCSrcE = 1; #1;
        chk("to_StallF", 32'(StallF), 1);
        chk("to_StallE", 32'(StallE), 1);
        chk("to_FlushW", 32'(FlushW), 1);
        chk("to_FlushD", 32'(FlushD), 0);
        step(); step();
        chk("to_sticky", 32'(MemTimeoutErr), 1);
        chk("to_sat", 32'(StallCnt), CMAX);
        #2 rst = 1; #1;
        chk("to_rst_err", 32'(MemTimeoutErr), 0);
        chk("to_rst_scnt", 32'(StallCnt), 0);
        chk("to_rst_fcnt", 32'(FlushCnt), 0);
        chk("to_rst_state", 32'(dut.state_q), 0);
        rst = 0;
        step(); clr_in();

        // Reset mid MEM_WAIT, then re-entry on the first edge
        MemReqM = 1; step(); step();
        chk("rmw_in_wait", 32'(dut.state_q), 1);
        #1 rst = 1; #1;
        chk("rmw_async_run", 32'(dut.state_q), 0);
        rst = 0;
        step();
        chk("rmw_reenter", 32'(dut.state_q), 1);
        clr_in(); step();

        // Counter saturation
        #1 rst = 1; #1 rst = 0;
        set_lw();
        repeat (14) step();
        chk("sat_14", 32'(StallCnt), 14);
        repeat (6) step();
        chk("sat_20", 32'(StallCnt), 15);
        repeat (3) step();
        chk("sat_hold", 32'(StallCnt), 15);
        clr_in(); step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage RV32 core. It generates the `clr`/flush and stall enables that the inter-stage pipeline registers (including the decode→execute control register) consume. It also produces the execute-stage forwarding selects and runs a small FSM that freezes the pipeline while data memory is not ready. A memory-wait timeout halts the core with a sticky error, and saturating counters record stall and redirect activity for debug.

## Interface
Parameters:
- `LOAD_SRC`, default 2'b01: the `ResultSrcE` encoding that marks a load.
- `MEM_TIMEOUT`, default 256: maximum number of consecutive not-ready cycles before halt. Must be ≥2.
- `CNT_W`, default 32: width of the performance counters.

Ports (name, direction, width, meaning):
- `clk` in 1: core clock.
- `rst` in 1: asynchronous reset, active-high.
- `Rs1D`, `Rs2D` in 5: source registers in decode.
- `Rs1E`, `Rs2E`, `RdE` in 5: source and destination registers in execute.
- `ResultSrcE` in 2: result-source select in execute.
- `PCSrcE` in 1: branch or jump taken in execute.
- `RdM` in 5, `RegWriteM` in 1: memory-stage writeback info.
- `RdW` in 5, `RegWriteW` in 1: writeback-stage writeback info.
- `MemReqM` in 1: load or store active in the memory stage.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the corresponding stage register.
- `FlushD`, `FlushE`, `FlushW` out 1: synchronous clear (`clr`) of the D, E and W stage registers.
- `ForwardAE`, `ForwardBE` out 2: operand select. 00 = register file, 01 = W result, 10 = M ALU result.
- `MemTimeoutErr` out 1: sticky error, set on timeout.
- `StallCnt`, `FlushCnt` out CNT_W: saturating performance counters.

## Operation
FSM states are RUN, MEM_WAIT and HALT. Encoding: RUN=0, MEM_WAIT=1, HALT=2.

Transitions:
- RUN→MEM_WAIT when `MemReqM & ~MemReadyM`.
- MEM_WAIT→RUN when `MemReadyM`.
- MEM_WAIT→HALT when `~MemReadyM` and `wait_cnt == MEM_TIMEOUT-1`.
- HALT is left only by reset.

Wait counter:
- `wait_cnt` is cleared on entry to MEM_WAIT and increments on each not-ready cycle in MEM_WAIT.
- It spans `$clog2(MEM_TIMEOUT)` bits.

Internal conditions (all outputs below are combinational from these and the current state):
- `memStall = MemReqM & ~MemReadyM` in RUN or MEM_WAIT; `memStall = 0` in HALT.
- `halt = (state == HALT)`.
- `lwStall = (ResultSrcE == LOAD_SRC) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D))`.

Outputs:
- `StallF = StallD = lwStall | memStall | halt`.
- `StallE = StallM = memStall | halt`.
- `FlushD = PCSrcE & ~memStall & ~halt`.
- `FlushE = (lwStall | PCSrcE) & ~memStall & ~halt`.
- `FlushW = memStall | halt`. This inserts a bubble into writeback.

Forwarding (applies identically to `ForwardBE` with `Rs2E`):
- `ForwardAE` = 10 if `RegWriteM & (RdM != 0) & (RdM == Rs1E)`.
- Otherwise 01 if `RegWriteW & (RdW != 0) & (RdW == Rs1E)`.
- Otherwise 00. The M stage takes priority over W.

Error and counters:
- `MemTimeoutErr` is 1 exactly when in HALT (registered, sticky).
- `StallCnt` increments on every cycle `StallF` is 1.
- `FlushCnt` increments on every cycle `FlushD` is 1.
- Both counters saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational with zero latency. The stage registers act on them at the next rising `clk`.
- State, `wait_cnt`, `MemTimeoutErr` and the counters are registered. They update on rising `clk`.
- Reset values: state RUN, `wait_cnt` 0, `MemTimeoutErr` 0, `StallCnt` 0, `FlushCnt` 0.
- Asserting `rst` mid-MEM_WAIT or in HALT returns to RUN immediately (asynchronously).
- During reset, the combinational outputs follow their inputs with state = RUN.
- Simultaneous events:
  - `PCSrcE` with `memStall`: the flush is suppressed. E is frozen, so `PCSrcE` persists, and the flush issues in the cycle `MemReadyM` rises.
  - `lwStall` with `PCSrcE`: `FlushE`=1, `FlushD`=1 and `StallF`=1. This is legal because the redirect loads PC through the mux path owned by the fetch stage.
- A single-cycle memory access (`MemReadyM`=1 in its first M cycle) causes no stall and no state change.
- `MemReqM` deasserting while in MEM_WAIT is treated as completion: the FSM returns to RUN.
- `MEM_TIMEOUT` boundary: exactly `MEM_TIMEOUT` consecutive not-ready cycles in MEM_WAIT → HALT on that edge. `MemReadyM` on the last cycle → RUN.

## Structure
- Shared package `core_pkg`:
  - `hazard_state_t` enum (RUN, MEM_WAIT, HALT).
  - Forward-select constants `FWD_RF`, `FWD_W`, `FWD_M`.
  - `RESULT_SRC_LOAD`, used as the `LOAD_SRC` default.
- One sub-module, `sat_counter` (parameterised width, `inc` input, saturating). It is instantiated twice, for `StallCnt` and `FlushCnt`.

## Test plan
- Load-use hazard: `ResultSrcE`=01, `RdE`=5, `Rs2D`=5 → `StallF`=`StallD`=`FlushE`=1 for one cycle, `StallCnt`=1.
- Forward priority: `RdM`=`RdW`=`Rs1E`=7 with `RegWriteM`=`RegWriteW`=1 → `ForwardAE`=10. With `RdM`=0 instead → `ForwardAE`=01. With x0 sources → 00.
- Memory wait: `MemReqM`=1 and `MemReadyM` low for 3 cycles while `PCSrcE`=1 → all stalls and `FlushW` high for 3 cycles, `FlushD` stays 0. When ready rises, `FlushD`=`FlushE`=1 and state returns to RUN.
- Timeout: `MEM_TIMEOUT`=4, `MemReadyM` held low → HALT after 4 MEM_WAIT cycles, `MemTimeoutErr`=1 and all stalls held. Assert `rst` → RUN, counters and error cleared.
- Saturation: `CNT_W`=4 with 20 consecutive stall cycles → `StallCnt`=15 and it holds there.
- Reset mid-MEM_WAIT: `rst` pulse while not ready → state RUN with no clock edge required. After release, the RUN→MEM_WAIT transition occurs on the first edge.
